// File: rtl/bmd_64_wdma_sched_pkg.sv
// bmd_64_wdma_sched_pkg: shared types and defaults for the write-DMA descriptor scheduler.
package bmd_64_wdma_sched_pkg;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_ARMED   = 2'd2,
    ST_STARVED = 2'd3
  } state_t;
  typedef struct packed {
    logic [7:0]  up_addr;
    logic [31:0] addr;
  } desc_t;
endpackage

// File: rtl/bmd_64_desc_fifo.sv
// bmd_64_desc_fifo: synchronous descriptor FIFO with show-ahead head and occupancy level.
module bmd_64_desc_fifo
  import bmd_64_wdma_sched_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  desc_t                    din,
  output desc_t                    dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  desc_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full is still accepted.
  assign do_push = push && (!full || do_pop);
  assign full    = level[AW];
  assign empty   = level == '0;
  assign dout    = mem[rp];
  always_ff @(posedge clk)
    if (do_push && !clr) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/bmd_64_wdma_desc_sched.sv
// bmd_64_wdma_desc_sched: queues host buffer descriptors and hands them one at a time to the write-DMA FSM.
// Define WDMA_SCHED_IRQ_COALESCE_EN to coalesce completion interrupts by irq_coalesce_i.
module bmd_64_wdma_desc_sched
  import bmd_64_wdma_sched_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_rst_i,
  input  logic                   sched_en_i,
  input  logic                   desc_wr_i,
  input  logic [31:0]            desc_addr_i,
  input  logic [7:0]             desc_up_addr_i,
  output logic                   desc_full_o,
  output logic [$clog2(DEPTH):0] desc_level_o,
  output logic                   desc_ovf_o,
  input  logic [3:0]             irq_coalesce_i,
  output logic [31:0]            next_wdma_addr_o,
  output logic [7:0]             next_wdma_up_addr_o,
  output logic                   next_wdma_valid_o,
  input  logic                   wdma_irq_i,
  output logic                   irq_o,
  output logic [CNT_W-1:0]       underrun_cnt_o,
  output logic [1:0]             state_o
);
  state_t state;
  desc_t  head;
  logic   fifo_empty, pop, irq_acc, issue, starve;
  assign state_o = state;
  assign pop     = state == ST_ISSUE;
  assign irq_acc = state == ST_ARMED && wdma_irq_i;
  assign issue   = sched_en_i && !fifo_empty && (state == ST_IDLE || state == ST_STARVED || irq_acc);
  assign starve  = irq_acc && sched_en_i && fifo_empty;
  bmd_64_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (init_rst_i),
    .push  (desc_wr_i),
    .pop   (pop),
    .din   ({desc_up_addr_i, desc_addr_i}),
    .dout  (head),
    .full  (desc_full_o),
    .empty (fifo_empty),
    .level (desc_level_o)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state               <= ST_IDLE;
      next_wdma_addr_o    <= '0;
      next_wdma_up_addr_o <= '0;
      next_wdma_valid_o   <= 1'b0;
      underrun_cnt_o      <= '0;
      desc_ovf_o          <= 1'b0;
    end else if (init_rst_i) begin
      state               <= ST_IDLE;
      next_wdma_addr_o    <= '0;
      next_wdma_up_addr_o <= '0;
      next_wdma_valid_o   <= 1'b0;
      underrun_cnt_o      <= '0;
      desc_ovf_o          <= 1'b0;
    end else begin
      state <= issue ? ST_ISSUE :
               state == ST_ISSUE ? ST_ARMED :
               (irq_acc || state == ST_STARVED) && !sched_en_i ? ST_IDLE :
               irq_acc ? ST_STARVED : state;
      next_wdma_valid_o <= issue;
      if (issue) {next_wdma_up_addr_o, next_wdma_addr_o} <= head;
      if (starve && !(&underrun_cnt_o)) underrun_cnt_o <= underrun_cnt_o + 1'b1;
      if (desc_wr_i && desc_full_o && !pop) desc_ovf_o <= 1'b1;
    end
`ifdef WDMA_SCHED_IRQ_COALESCE_EN
  logic [3:0] coal_cnt, thr;
  assign thr = irq_coalesce_i == 4'd0 ? 4'd1 : irq_coalesce_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      coal_cnt <= '0;
      irq_o    <= 1'b0;
    end else if (init_rst_i) begin
      coal_cnt <= '0;
      irq_o    <= 1'b0;
    end else if (starve || (irq_acc && {1'b0, coal_cnt} + 5'd1 >= {1'b0, thr})) begin
      coal_cnt <= '0;
      irq_o    <= 1'b1;
    end else begin
      irq_o <= 1'b0;
      if (irq_acc) coal_cnt <= coal_cnt + 1'b1;
    end
`else
  logic unused_coal;
  assign unused_coal = ^irq_coalesce_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) irq_o <= 1'b0;
    else if (init_rst_i) irq_o <= 1'b0;
    else irq_o <= irq_acc;
`endif
endmodule
